// File: rtl/definesPkg.sv
// Shared AHB-Lite widths, bus encodings and slave FSM states.
package definesPkg;

  localparam int unsigned ADDRESS_WIDTH = 32;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned HSIZE_WIDTH   = 3;
  localparam int unsigned BURST_SIZE    = 3;
  localparam int unsigned TRANSFER_TYPE = 2;

  typedef enum logic [TRANSFER_TYPE-1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_t;

  typedef enum logic [HSIZE_WIDTH-1:0] {
    BYTE     = 3'd0,
    HALFWORD = 3'd1,
    WORD     = 3'd2,
    DWORD    = 3'd3
  } hsize_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StErr1,
    StErr2
  } slave_state_t;

  // Little-endian byte-lane mask for a transfer of 2**size bytes at lane offset.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offset);
    logic [7:0] base;
    base = (8'd1 << (4'd1 << size)) - 8'd1;
    return base << offset;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM: byte-enable synchronous write port, asynchronous read port.
module ahb_sram_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WIDTH / 8; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, programmable wait states,
// two-cycle ERROR response for size, alignment and range violations.
module ahb_lite_sram_slave #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_DEPTH     = 1024,
  parameter int unsigned WAIT_STATES   = 0
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [ADDRESS_WIDTH-1:0] HADDR,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [1:0]               HTRANS,
  input  logic [DATA_WIDTH-1:0]    HWDATA,
  output logic [DATA_WIDTH-1:0]    HRDATA,
  output logic                     HREADY,
  output logic                     HRESP
);

  import definesPkg::*;

  localparam int unsigned NB        = DATA_WIDTH / 8;
  localparam int unsigned OFF_W     = $clog2(NB);
  localparam int unsigned AW        = $clog2(MEM_DEPTH);
  localparam int unsigned MEM_BYTES = MEM_DEPTH * NB;

  slave_state_t    state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_write_q, pend_write_d;
  logic [AW-1:0]   pend_word_q, pend_word_d;
  logic [NB-1:0]   pend_be_q, pend_be_d;
  logic [DATA_WIDTH-1:0] hrdata_q, rdata;

  logic       active, size_err, align_err, range_err, legal;
  logic [2:0] lane_off;
  logic [7:0] be_all;
  logic       mem_we, rd_phase;
  logic       unused_bits;

  assign active    = (HTRANS == NONSEQ) || (HTRANS == SEQ);
  assign size_err  = 32'(HSIZE) > OFF_W;
  assign align_err = (HADDR[7:0] & ((8'd1 << HSIZE) - 8'd1)) != 8'd0;
  assign range_err = 64'(HADDR) >= 64'(MEM_BYTES);
  assign legal     = !(size_err || align_err || range_err);
  assign lane_off  = HADDR[2:0] & 3'(NB - 1);
  assign be_all    = lane_mask(HSIZE, lane_off);
  assign unused_bits = ^{HBURST, be_all};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_write_d = pend_write_q;
    pend_word_d  = pend_word_q;
    pend_be_d    = pend_be_q;
    HREADY       = 1'b1;
    HRESP        = OKAY;

    unique case (state_q)
      StIdle: HREADY = 1'b1;
      StWait: HREADY = (cnt_q == 4'd0);
      StErr1: begin
        HREADY = 1'b0;
        HRESP  = ERROR;
      end
      StErr2: HRESP = ERROR;
      default: HREADY = 1'b1;
    endcase

    if (HREADY) begin
      // Current data phase completes on this edge; sample the next address phase.
      pend_valid_d = active && legal;
      pend_write_d = HWRITE;
      pend_word_d  = HADDR[OFF_W +: AW];
      pend_be_d    = be_all[NB-1:0];
      if (!active) begin
        state_d = StIdle;
      end else if (!legal) begin
        state_d = StErr1;
      end else if (WAIT_STATES > 0) begin
        state_d = StWait;
        cnt_d   = 4'(WAIT_STATES);
      end else begin
        state_d = StIdle;
      end
    end else if (state_q == StErr1) begin
      state_d = StErr2;
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Async read of the word just committed on the previous edge gives write->read forwarding.
  assign mem_we   = HREADY && pend_valid_q && pend_write_q;
  assign rd_phase = HREADY && pend_valid_q && !pend_write_q;
  assign HRDATA   = rd_phase ? rdata : hrdata_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_write_q <= 1'b0;
      pend_word_q  <= '0;
      pend_be_q    <= '0;
      hrdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_write_q <= pend_write_d;
      pend_word_q  <= pend_word_d;
      pend_be_q    <= pend_be_d;
      hrdata_q     <= HRDATA;
    end
  end

  ahb_sram_array #(
    .DEPTH(MEM_DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (HCLK),
    .we   (mem_we),
    .be   (pend_be_q),
    .waddr(pend_word_q),
    .wdata(HWDATA),
    .raddr(pend_word_q),
    .rdata(rdata)
  );

endmodule
